// File: rtl/vx_execute_split.sv
// Execute-interface transmit splitter: one NUM_THREADS-wide instruction goes out as
// NUM_THREADS/NUM_LANES pid/sop/eop-tagged packets. Optional VX_EXEC_SPLIT_SKIP_EN skips empty chunks.
module vx_execute_split #(
    parameter int NUM_THREADS = 16,
    parameter int NUM_LANES   = 4,
    parameter int PID_WIDTH   = ((NUM_THREADS / NUM_LANES) > 1) ? $clog2(NUM_THREADS / NUM_LANES) : 1,
    parameter int XLEN        = 32,
    parameter int UUID_W      = 32,
    parameter int NW_W        = 2,
    parameter int PC_W        = 32,
    parameter int OP_TYPE_W   = 4,
    parameter int OP_MOD_W    = 3,
    parameter int IMM_W       = 32,
    parameter int RD_W        = 6,
    parameter int TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    parameter int MCNT_W      = 8,
    parameter int MID_W       = 8,
    parameter int MTYPE_W     = 2,
    parameter int MROW_W      = 4,
    localparam int CMN_W = UUID_W + NW_W + PC_W + OP_TYPE_W + OP_MOD_W + 3 + IMM_W + RD_W
                         + TID_W + MCNT_W + MID_W + MTYPE_W + MROW_W,
    localparam int IN_W  = CMN_W + NUM_THREADS + 3 * NUM_THREADS * XLEN + 1 + 2,
    localparam int OUT_W = CMN_W + NUM_LANES + 3 * NUM_LANES * XLEN + PID_WIDTH + 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             exe_if_valid,
    output logic [OUT_W-1:0] exe_if_data,
    input  logic             exe_if_ready,
    output logic             busy
);

    localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES;

    typedef struct packed {
        logic [UUID_W-1:0]    uuid;
        logic [NW_W-1:0]      wid;
        logic [PC_W-1:0]      PC;
        logic [OP_TYPE_W-1:0] op_type;
        logic [OP_MOD_W-1:0]  op_mod;
        logic                 wb;
        logic                 use_PC;
        logic                 use_imm;
        logic [IMM_W-1:0]     imm;
        logic [RD_W-1:0]      rd;
        logic [TID_W-1:0]     tid;
        logic [MCNT_W-1:0]    m_instr_cnt;
        logic [MID_W-1:0]     m_instr_id;
        logic [MTYPE_W-1:0]   m_type;
        logic [MROW_W-1:0]    m_row_size;
    } cmn_t;

    typedef struct packed {
        cmn_t                              cmn;
        logic [NUM_THREADS-1:0]            tmask;
        logic [NUM_THREADS-1:0][XLEN-1:0]  rs1_data;
        logic [NUM_THREADS-1:0][XLEN-1:0]  rs2_data;
        logic [NUM_THREADS-1:0][XLEN-1:0]  rs3_data;
        logic [0:0]                        pid;
        logic                              sop;
        logic                              eop;
    } in_t;

    typedef struct packed {
        cmn_t                              cmn;
        logic [NUM_LANES-1:0]              tmask;
        logic [NUM_LANES-1:0][XLEN-1:0]    rs1_data;
        logic [NUM_LANES-1:0][XLEN-1:0]    rs2_data;
        logic [NUM_LANES-1:0][XLEN-1:0]    rs3_data;
        logic [PID_WIDTH-1:0]              pid;
        logic                              sop;
        logic                              eop;
    } out_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Lowest set chunk at index >= lo; 0 when none is left.
    function automatic logic [PID_WIDTH-1:0] find_first(input logic [NUM_PACKETS-1:0] mask,
                                                        input int unsigned lo);
        logic [PID_WIDTH-1:0]   idx;
        logic                   found;
        logic [NUM_PACKETS-1:0] sh;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_PACKETS; k++) begin
            sh = mask >> k;
            if (sh[0] && (k >= lo) && !found) begin
                found = 1'b1;
                idx   = PID_WIDTH'(k);
            end
        end
        return idx;
    endfunction

    function automatic logic has_after(input logic [NUM_PACKETS-1:0] mask,
                                       input logic [PID_WIDTH-1:0] idx);
        return (mask >> (32'(idx) + 32'd1)) != '0;
    endfunction

    function automatic out_t make_chunk(input in_t src, input logic [PID_WIDTH-1:0] idx,
                                        input logic sop, input logic eop);
        out_t                         o;
        logic [NUM_THREADS-1:0]       tsh;
        logic [NUM_THREADS*XLEN-1:0]  dsh;
        o.cmn      = src.cmn;
        tsh        = src.tmask >> (NUM_LANES * int'(idx));
        o.tmask    = tsh[NUM_LANES-1:0];
        dsh        = src.rs1_data >> (XLEN * NUM_LANES * int'(idx));
        o.rs1_data = dsh[NUM_LANES*XLEN-1:0];
        dsh        = src.rs2_data >> (XLEN * NUM_LANES * int'(idx));
        o.rs2_data = dsh[NUM_LANES*XLEN-1:0];
        dsh        = src.rs3_data >> (XLEN * NUM_LANES * int'(idx));
        o.rs3_data = dsh[NUM_LANES*XLEN-1:0];
        o.pid      = idx;
        o.sop      = sop;
        o.eop      = eop;
        return o;
    endfunction

    state_t                 state;
    in_t                    in_s;
    in_t                    buf_q;
    out_t                   out_q;
    out_t                   first_pkt;
    out_t                   next_pkt;
    logic [PID_WIDTH-1:0]   pid_q;
    logic [PID_WIDTH-1:0]   first_idx;
    logic [PID_WIDTH-1:0]   next_idx;
    logic [NUM_PACKETS-1:0] mask_q;
    logic [NUM_PACKETS-1:0] in_mask;
    logic                   rdy_en_q;
    logic                   last_chunk;
    logic                   in_fire;
    logic                   out_fire;
    logic                   unused_ctl;

    assign in_s = in_data;

`ifdef VX_EXEC_SPLIT_SKIP_EN
    always_comb begin : skip_mask
        logic [NUM_THREADS-1:0] tsh;
        in_mask = '0;
        tsh     = '0;
        for (int unsigned k = 0; k < NUM_PACKETS; k++) begin
            tsh = in_s.tmask >> (k * NUM_LANES);
            if (|tsh[NUM_LANES-1:0]) begin
                in_mask = in_mask | (NUM_PACKETS'(1) << k);
            end
        end
    end
`else
    assign in_mask = '1;
`endif

    // An all-empty instruction (skip build) falls back to a single pid 0 / sop+eop packet.
    assign first_idx  = find_first(in_mask, 32'd0);
    assign next_idx   = find_first(mask_q, 32'(pid_q) + 32'd1);
    assign last_chunk = !has_after(mask_q, pid_q);
    assign first_pkt  = make_chunk(in_s, first_idx, 1'b1, !has_after(in_mask, first_idx));
    assign next_pkt   = make_chunk(buf_q, next_idx, 1'b0, !has_after(mask_q, next_idx));

    assign in_ready     = rdy_en_q & ((state == IDLE) | ((state == SEND) & last_chunk & exe_if_ready));
    assign exe_if_valid = (state == SEND);
    assign exe_if_data  = out_q;
    assign busy         = (state == SEND);
    assign in_fire      = in_valid & in_ready;
    assign out_fire     = exe_if_valid & exe_if_ready;

    // Incoming pid/sop/eop are regenerated per chunk and deliberately ignored.
    assign unused_ctl = ^{in_s.pid, in_s.sop, in_s.eop, buf_q.pid, buf_q.sop, buf_q.eop};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            buf_q    <= '0;
            out_q    <= '0;
            pid_q    <= '0;
            mask_q   <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            // in_fire while SEND implies the last chunk is handshaking this cycle.
            if (in_fire) begin
                state  <= SEND;
                buf_q  <= in_s;
                mask_q <= in_mask;
                pid_q  <= first_idx;
                out_q  <= first_pkt;
            end else if (out_fire) begin
                if (last_chunk) begin
                    state <= IDLE;
                end else begin
                    pid_q <= next_idx;
                    out_q <= next_pkt;
                end
            end
        end
    end

endmodule

// File: tb/tb_vx_execute_split.sv
// Self-checking bench for vx_execute_split (NUM_THREADS=16, NUM_LANES=4) against a queue-based
// packet model; follows VX_EXEC_SPLIT_SKIP_EN when the build defines it.
module tb_vx_execute_split;

    localparam int NT = 16, NL = 4, NP = NT / NL, PIDW = 2, XLEN = 32;
    localparam int TID_W = 4;
`ifdef VX_EXEC_SPLIT_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] uuid;
        logic [1:0]  wid;
        logic [31:0] PC;
        logic [3:0]  op_type;
        logic [2:0]  op_mod;
        logic        wb;
        logic        use_PC;
        logic        use_imm;
        logic [31:0] imm;
        logic [5:0]  rd;
        logic [TID_W-1:0] tid;
        logic [7:0]  m_instr_cnt;
        logic [7:0]  m_instr_id;
        logic [1:0]  m_type;
        logic [3:0]  m_row_size;
    } cmn_t;

    typedef struct packed {
        cmn_t                     cmn;
        logic [NT-1:0]            tmask;
        logic [NT-1:0][XLEN-1:0]  rs1_data;
        logic [NT-1:0][XLEN-1:0]  rs2_data;
        logic [NT-1:0][XLEN-1:0]  rs3_data;
        logic [0:0]               pid;
        logic                     sop;
        logic                     eop;
    } in_t;

    typedef struct packed {
        cmn_t                     cmn;
        logic [NL-1:0]            tmask;
        logic [NL-1:0][XLEN-1:0]  rs1_data;
        logic [NL-1:0][XLEN-1:0]  rs2_data;
        logic [NL-1:0][XLEN-1:0]  rs3_data;
        logic [PIDW-1:0]          pid;
        logic                     sop;
        logic                     eop;
    } out_t;

    localparam int IN_W = $bits(in_t);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0;
    in_t  in_data = '0;
    logic in_ready;
    logic exe_valid;
    out_t exe_data;
    logic exe_ready = 1'b0;
    logic busy;

    vx_execute_split #(.NUM_THREADS(NT), .NUM_LANES(NL)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .exe_if_valid (exe_valid),
        .exe_if_data  (exe_data),
        .exe_if_ready (exe_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    out_t exp_q[$];
    out_t seen[$];
    in_t  pend_q[$];

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_pkt(input string tag, input out_t obs, input out_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed pid=%0d sop=%b eop=%b tm=%h uuid=%h data=%h expected pid=%0d sop=%b eop=%b tm=%h uuid=%h data=%h",
                   tag, obs.pid, obs.sop, obs.eop, obs.tmask, obs.cmn.uuid, obs.rs1_data,
                   exp.pid, exp.sop, exp.eop, exp.tmask, exp.cmn.uuid, exp.rs1_data);
        end
    endtask

    function automatic in_t gen_instr(input logic [NT-1:0] tm, input bit ramp);
        logic [IN_W-1:0]      r;
        logic [NT*XLEN-1:0]   v;
        in_t                  x;
        r = '0;
        for (int unsigned i = 0; i < (IN_W + 31) / 32; i++) r = (r << 32) | IN_W'($urandom);
        x = r;
        x.tmask = tm;
        if (ramp) begin
            v = '0;
            for (int unsigned t = 0; t < NT; t++) v = v | ((NT*XLEN)'(t) << (t * XLEN));
            x.rs1_data = v;
        end
        return x;
    endfunction

    function automatic logic [NT-1:0] rand_mask();
        logic [NT-1:0] m;
        logic [NL-1:0] s;
        m = '0;
        for (int unsigned k = 0; k < NP; k++) begin
            case ($urandom_range(0, 3))
                0, 3:    s = '0;
                1:       s = '1;
                default: s = NL'($urandom);
            endcase
            m = m | (NT'(s) << (k * NL));
        end
        return m;
    endfunction

    // Reference: list the chunk indices that go out, then slice each one.
    task automatic expand(input in_t ins);
        int unsigned        ks[$];
        logic [NT-1:0]      tsh;
        logic [NT*XLEN-1:0] d;
        out_t               o;
        for (int unsigned k = 0; k < NP; k++) begin
            tsh = ins.tmask >> (k * NL);
            if (!SKIP || tsh[NL-1:0] != '0) ks.push_back(k);
        end
        if (ks.size() == 0) ks.push_back(0);
        for (int unsigned i = 0; i < ks.size(); i++) begin
            o.cmn      = ins.cmn;
            tsh        = ins.tmask >> (ks[i] * NL);
            o.tmask    = tsh[NL-1:0];
            d          = ins.rs1_data >> (ks[i] * NL * XLEN);
            o.rs1_data = d[NL*XLEN-1:0];
            d          = ins.rs2_data >> (ks[i] * NL * XLEN);
            o.rs2_data = d[NL*XLEN-1:0];
            d          = ins.rs3_data >> (ks[i] * NL * XLEN);
            o.rs3_data = d[NL*XLEN-1:0];
            o.pid      = PIDW'(ks[i]);
            o.sop      = (i == 0);
            o.eop      = (i == ks.size() - 1);
            exp_q.push_back(o);
        end
    endtask

    // Drives pend_q into the DUT and checks every cycle; ready_mode 0=always, 1=alternate, 2=random.
    task automatic run_step(input string tag, input int ready_mode, input int stop_hs, output int hs);
        int   cyc;
        bit   r;
        bit   stall_prev;
        out_t prev_data;
        cyc = 0;
        hs = 0;
        stall_prev = 1'b0;
        prev_data = '0;
        seen.delete();
        while ((pend_q.size() > 0 || exp_q.size() > 0) && cyc < 300 && !(stop_hs > 0 && hs >= stop_hs)) begin
            @(negedge clk);
            cyc++;
            check_bit({tag, ".valid"}, exe_valid, exp_q.size() > 0);
            check_bit({tag, ".busy"}, busy, exp_q.size() > 0);
            if (exe_valid && exp_q.size() > 0) check_pkt({tag, ".pkt"}, exe_data, exp_q[0]);
            if (stall_prev && exe_valid) check_pkt({tag, ".hold"}, exe_data, prev_data);
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2) == 1;
                default: r = $urandom_range(0, 1) == 1;
            endcase
            exe_ready = r;
            in_valid  = pend_q.size() > 0;
            in_data   = in_valid ? pend_q[0] : gen_instr(NT'($urandom), 1'b0);
            #1;
            check_bit({tag, ".in_ready"}, in_ready, (exp_q.size() == 0) || (exp_q.size() == 1 && r));
            stall_prev = exe_valid && !r;
            prev_data  = exe_data;
            if (exe_valid && r && exp_q.size() > 0) begin
                seen.push_back(exe_data);
                void'(exp_q.pop_front());
                hs++;
            end
            if (in_valid && in_ready) expand(pend_q.pop_front());
        end
        check_bit({tag, ".in_budget"}, cyc < 300, 1'b1);
        if (stop_hs == 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            check_bit({tag, ".idle_valid"}, exe_valid, 1'b0);
            check_bit({tag, ".idle_busy"}, busy, 1'b0);
        end
    endtask

    initial begin
        int   hs;
        int   n_exp;
        in_t  a;
        in_t  b;

        // Reset behaviour
        #1;
        check_bit("rst.valid", exe_valid, 1'b0);
        check_bit("rst.busy", busy, 1'b0);
        check_bit("rst.in_ready", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_bit("rst.in_ready_before_edge", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check_bit("rst.in_ready_after_edge", in_ready, 1'b1);

        // 1: full mask, ramp data, continuous ready
        pend_q.push_back(gen_instr(16'hFFFF, 1'b1));
        run_step("t1", 0, 0, hs);
        check_int("t1.handshakes", hs, 4);
        check_bit("t1.pid2_rs1", seen[2].rs1_data === {32'd11, 32'd10, 32'd9, 32'd8}, 1'b1);
        check_bit("t1.sop0", seen[0].sop, 1'b1);
        check_bit("t1.eop3", seen[3].eop, 1'b1);

        // 2: single populated chunk
        pend_q.push_back(gen_instr(16'h0F00, 1'b0));
        run_step("t2", 0, 0, hs);
        check_int("t2.handshakes", hs, SKIP ? 1 : 4);
        check_int("t2.first_pid", int'(seen[0].pid), SKIP ? 2 : 0);

        // 3: ready alternating
        pend_q.push_back(gen_instr(16'hFFFF, 1'b0));
        run_step("t3", 1, 0, hs);
        check_int("t3.handshakes", hs, 4);
        for (int unsigned i = 0; i < 4; i++) check_int("t3.pid_order", int'(seen[i].pid), int'(i));

        // 4: back-to-back instructions
        a = gen_instr(16'hFFFF, 1'b0);
        b = gen_instr(16'hFFFF, 1'b0);
        a.cmn.uuid = 32'hAAAA_0001;
        b.cmn.uuid = 32'hBBBB_0002;
        pend_q.push_back(a);
        pend_q.push_back(b);
        run_step("t4", 0, 0, hs);
        check_int("t4.handshakes", hs, 8);
        for (int unsigned i = 0; i < 8; i++)
            check_int("t4.uuid", int'(seen[i].cmn.uuid), (i < 4) ? int'(32'hAAAA_0001) : int'(32'hBBBB_0002));

        // 5: asynchronous reset after the pid1 handshake
        pend_q.push_back(gen_instr(16'hFFFF, 1'b0));
        run_step("t5a", 0, 2, hs);
        check_int("t5.pre_reset_hs", hs, 2);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_bit("t5.valid_async", exe_valid, 1'b0);
        check_bit("t5.busy_async", busy, 1'b0);
        check_bit("t5.in_ready_async", in_ready, 1'b0);
        exp_q.delete();
        pend_q.delete();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        pend_q.push_back(gen_instr(16'hFFFF, 1'b0));
        run_step("t5b", 0, 0, hs);
        check_int("t5.post_reset_hs", hs, 4);
        check_int("t5.restart_pid", int'(seen[0].pid), 0);
        check_bit("t5.restart_sop", seen[0].sop, 1'b1);

        // 6: empty mask
        pend_q.push_back(gen_instr(16'h0000, 1'b0));
        run_step("t6", 0, 0, hs);
        check_int("t6.handshakes", hs, SKIP ? 1 : 4);
        check_bit("t6.eop_first", seen[0].eop, SKIP ? 1'b1 : 1'b0);

        // Randomised masks and ready
        n_exp = 0;
        for (int unsigned i = 0; i < 24; i++) begin
            a = gen_instr(rand_mask(), 1'b0);
            pend_q.push_back(a);
        end
        for (int unsigned i = 0; i < pend_q.size(); i++) begin
            int unsigned cnt;
            logic [NT-1:0] tsh;
            cnt = 0;
            for (int unsigned k = 0; k < NP; k++) begin
                tsh = pend_q[i].tmask >> (k * NL);
                if (!SKIP || tsh[NL-1:0] != '0) cnt++;
            end
            n_exp += (cnt == 0) ? 1 : int'(cnt);
        end
        run_step("rnd", 2, 0, hs);
        check_int("rnd.handshakes", hs, n_exp);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
